// File: rtl/mapper_mode_sched.sv
// mapper_mode_sched
// Per-frame controller that shares one input word stream and one output
// symbol stream between the constellation mapper lanes. A descriptor
// {mode, len} selects a lane. Exactly len 32-bit words are steered into
// that lane. The lane's symbols are then forwarded until the frame's bit
// budget is used up. The last symbol is flagged, and only after that is the
// next descriptor accepted.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   cfg_data/valid/ready descriptor {mode[2:0], len[LEN_W-1:0]}
//   t0_data/valid/ready  payload words from the framer/scrambler
//   m_data/last          payload broadcast to all mapper lanes
//   m_valid/m_ready      per-lane handshake, only the selected lane is valid
//   s_data/valid/ready   per-lane symbol outputs (lane k at [32k+31:32k])
//   i_data/valid/last    symbol stream out, i_last on final symbol of frame
//   i_ready              downstream ready
//   busy                 frame in progress (FEED or DRAIN)
//   cfg_err              one-cycle pulse after a rejected descriptor
module mapper_mode_sched #(
  parameter int LEN_W     = 16,
  parameter int NUM_LANES = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_W+2:0]        cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [31:0]             t0_data,
  input  logic                    t0_valid,
  output logic                    t0_ready,
  output logic [31:0]             m_data,
  output logic                    m_last,
  output logic [NUM_LANES-1:0]    m_valid,
  input  logic [NUM_LANES-1:0]    m_ready,
  input  logic [32*NUM_LANES-1:0] s_data,
  input  logic [NUM_LANES-1:0]    s_valid,
  output logic [NUM_LANES-1:0]    s_ready,
  output logic [31:0]             i_data,
  output logic                    i_valid,
  output logic                    i_last,
  input  logic                    i_ready,
  output logic                    busy,
  output logic                    cfg_err
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [LEN_W+4:0] bits_q, bits_d;
  logic             cfg_err_q, cfg_err_d;

  logic [2:0]       cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic [2:0]       bps;
  logic [LEN_W+4:0] bps_ext;
  logic             bits_last;

  logic [NUM_LANES-1:0] sel;
  logic [31:0]          lane_data;
  logic                 lane_s_valid;
  logic                 lane_m_ready;

  logic active, feeding, word_hs, sym_hs;

  assign cfg_mode = cfg_data[LEN_W+2:LEN_W];
  assign cfg_len  = cfg_data[LEN_W-1:0];

  // Bits carried per symbol for each mode code.
  always_comb begin
    case (mode_q)
      3'd0:    bps = 3'd1;
      3'd1:    bps = 3'd2;
      3'd2:    bps = 3'd4;
      3'd3:    bps = 3'd5;
      3'd4:    bps = 3'd6;
      default: bps = 3'd1;
    endcase
  end

  assign bps_ext = (LEN_W+5)'(bps);
  // The final symbol may be padded, so "last" means the remaining bits fit
  // in one symbol.
  assign bits_last = (bits_q <= bps_ext);

  // Lane selection: one-hot mask plus muxed per-lane signals.
  always_comb begin
    sel          = '0;
    lane_data    = '0;
    lane_s_valid = 1'b0;
    lane_m_ready = 1'b0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (mode_q == 3'(k)) begin
        sel[k]       = 1'b1;
        lane_data    = s_data[32*k +: 32];
        lane_s_valid = s_valid[k];
        lane_m_ready = m_ready[k];
      end
    end
  end

  assign active  = (state_q != IDLE);
  assign feeding = (state_q == FEED);
  assign word_hs = feeding && t0_valid && lane_m_ready;
  assign sym_hs  = active && lane_s_valid && i_ready;

  // Datapath outputs are purely combinational. cfg_ready is also gated by
  // rst so that every output reads 0 while reset is held.
  always_comb begin
    cfg_ready = (state_q == IDLE) && !rst;
    t0_ready  = feeding && lane_m_ready;
    m_data    = feeding ? t0_data : '0;
    m_valid   = (feeding && t0_valid) ? sel : '0;
    m_last    = feeding && (words_q == LEN_W'(1));
    s_ready   = (active && i_ready) ? sel : '0;
    i_data    = active ? lane_data : '0;
    i_valid   = active && lane_s_valid;
    i_last    = active && bits_last;
    busy      = active;
    cfg_err   = cfg_err_q;
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    words_d   = words_q;
    bits_d    = bits_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          mode_d  = cfg_mode;
          words_d = cfg_len;
          bits_d  = {cfg_len, 5'b0};
          if (int'(cfg_mode) >= NUM_LANES || cfg_len == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = FEED;
          end
        end
      end
      FEED: begin
        if (word_hs) begin
          words_d = words_q - LEN_W'(1);
          if (words_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Termination is only honoured here. An early final symbol seen in
        // FEED does not end the frame.
        if (sym_hs && bits_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sym_hs) begin
      bits_d = (bits_q > bps_ext) ? (bits_q - bps_ext) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      words_q   <= '0;
      bits_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      words_q   <= words_d;
      bits_q    <= bits_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_mapper_mode_sched.sv
module tb_mapper_mode_sched;

  localparam int LEN_W  = 16;
  localparam int NL     = 5;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic [LEN_W+2:0]  cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [31:0]       t0_data;
  logic              t0_valid;
  logic              t0_ready;
  logic [31:0]       m_data;
  logic              m_last;
  logic [NL-1:0]     m_valid;
  logic [NL-1:0]     m_ready;
  logic [32*NL-1:0]  s_data;
  logic [NL-1:0]     s_valid;
  logic [NL-1:0]     s_ready;
  logic [31:0]       i_data;
  logic              i_valid;
  logic              i_last;
  logic              i_ready;
  logic              busy;
  logic              cfg_err;

  int n_cmp = 0;
  int n_bad = 0;
  int bps_tab [5] = '{1, 2, 4, 5, 6};

  logic [31:0] wq [$];
  logic [31:0] sq [$];

  always #5 clk = ~clk;

  mapper_mode_sched #(.LEN_W(LEN_W), .NUM_LANES(NL)) dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .i_data(i_data), .i_valid(i_valid), .i_last(i_last), .i_ready(i_ready),
    .busy(busy), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_t0_ready"},  t0_ready,  0);
    check({tag, "_m_data"},    m_data,    0);
    check({tag, "_m_last"},    m_last,    0);
    check({tag, "_m_valid"},   m_valid,   0);
    check({tag, "_s_ready"},   s_ready,   0);
    check({tag, "_i_data"},    i_data,    0);
    check({tag, "_i_valid"},   i_valid,   0);
    check({tag, "_i_last"},    i_last,    0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_cfg_err"},   cfg_err,   0);
  endtask

  // Wait for cfg_ready, present a descriptor for one cycle.
  task automatic send_cfg(input int m, input int len);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    check("cfg_ready_wait", cfg_ready, 1);
    cfg_data  = {3'(m), 16'(len)};
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Runs one frame: bench acts as framer, mapper lane m and downstream sink.
  // Words and symbols are pushed to scoreboards when driven and popped when
  // the DUT hands them over. nsym is the expected symbol count of the frame.
  task automatic run_frame(input int m, input int len, input int nsym, input bit thr,
                           input bit has_next, input int nm, input int nl);
    int  wpush = 0, wsent = 0, spush = 0, sgot = 0;
    bit  hs_s = 0, hs_t = 0, done = 0;
    logic [NL-1:0] selm;
    logic [31:0]   exp, sym;
    selm = NL'(1) << m;
    send_cfg(m, len);
    if (has_next) begin
      cfg_data  = {3'(nm), 16'(nl)};
      cfg_valid = 1'b1;
    end
    t0_valid = 1'b0;
    for (int k = 0; k < NL; k++) begin
      s_valid[k]        = (k != m);
      s_data[32*k +: 32] = 32'hDEAD_0000 | 32'(k);
    end
    for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
      if (hs_t || !t0_valid) begin
        if (wpush < len && (!thr || $urandom_range(0, 1) == 1)) begin
          t0_data  = $urandom;
          t0_valid = 1'b1;
          wq.push_back(t0_data);
          wpush++;
        end else begin
          t0_valid = 1'b0;
        end
      end
      m_ready = thr ? NL'($urandom) : '1;
      if (hs_s || !s_valid[m]) begin
        if (spush < nsym && spush * bps_tab[m] < 32 * wsent &&
            (!thr || $urandom_range(0, 1) == 1)) begin
          sym = $urandom;
          s_data[32*m +: 32] = sym;
          s_valid[m] = 1'b1;
          sq.push_back(sym);
          spush++;
        end else begin
          s_valid[m] = 1'b0;
        end
      end
      i_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("busy", busy, 1);
      check("m_valid_other", m_valid & ~selm, 0);
      check("s_ready_other", s_ready & ~selm, 0);
      if (wsent < len) begin
        check("t0_ready", t0_ready, m_ready[m]);
        check("m_valid_sel", m_valid[m], t0_valid);
      end else begin
        check("t0_ready_drain", t0_ready, 0);
        check("m_valid_drain", m_valid, 0);
      end
      hs_t = t0_valid && m_ready[m] && (wsent < len);
      if (hs_t) begin
        exp = wq.pop_front();
        check("m_data", m_data, exp);
        check("m_last", m_last, wsent == len - 1);
        wsent++;
      end
      check("i_valid", i_valid, s_valid[m]);
      check("s_ready_sel", s_ready[m], i_ready);
      hs_s = s_valid[m] && i_ready;
      if (hs_s) begin
        exp = sq.pop_front();
        check("i_data", i_data, exp);
        check("i_last", i_last, sgot == nsym - 1);
        if (sgot == nsym - 1) done = 1;
        sgot++;
      end
      if (has_next) check("cfg_ready_blocked", cfg_ready, 0);
      @(negedge clk);
    end
    check("frame_done", done, 1);
    t0_valid   = 1'b0;
    s_valid[m] = 1'b0;
    #1;
    check("end_busy", busy, 0);
    check("end_cfg_ready", cfg_ready, 1);
    check("end_s_ready", s_ready, 0);
    check("end_i_valid", i_valid, 0);
    check("end_words_left", wq.size(), 0);
    check("end_syms_left", sq.size(), 0);
    check("end_sym_count", sgot, nsym);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    t0_data   = '0;
    t0_valid  = 1'b0;
    m_ready   = '0;
    s_data    = '0;
    s_valid   = '0;
    i_ready   = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_cfg_ready", cfg_ready, 1);
    check("post_reset_busy", busy, 0);
    @(negedge clk);

    // QAM32 len=2: 64 bits -> 13 symbols.
    run_frame(3, 2, 13, 0, 0, 0, 0);
    // BPSK len=1 -> 32 symbols; QAM64 len=3 -> 16 symbols.
    run_frame(0, 1, 32, 0, 0, 0, 0);
    run_frame(4, 3, 16, 0, 0, 0, 0);

    // Rejected descriptors: bad mode, then zero length.
    @(negedge clk);
    t0_valid = 1'b1;
    m_ready  = '1;
    s_valid  = '1;
    i_ready  = 1'b1;
    cfg_data  = {3'd6, 16'd5};
    cfg_valid = 1'b1;
    #1;
    check("err1_cfg_ready", cfg_ready, 1);
    check("err1_m_valid_pre", m_valid, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    check("err1_cfg_err", cfg_err, 1);
    check("err1_busy", busy, 0);
    check("err1_m_valid", m_valid, 0);
    check("err1_cfg_ready_after", cfg_ready, 1);
    @(negedge clk);
    #1;
    check("err1_cfg_err_clear", cfg_err, 0);
    cfg_data  = {3'd2, 16'd0};
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    check("err2_cfg_err", cfg_err, 1);
    check("err2_busy", busy, 0);
    check("err2_m_valid", m_valid, 0);
    check("err2_t0_ready", t0_ready, 0);
    check("err2_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    #1;
    check("err2_cfg_err_clear", cfg_err, 0);
    t0_valid = 1'b0;
    s_valid  = '0;
    @(negedge clk);

    // Throttled QAM16 len=5 -> 40 symbols.
    run_frame(2, 5, 40, 1, 0, 0, 0);

    // Back-to-back: QPSK len=1 (16 symbols) with QAM32 len=1 held pending.
    run_frame(1, 1, 16, 0, 1, 3, 1);
    run_frame(3, 1, 7, 0, 0, 0, 0);

    // Reset in the middle of FEED.
    @(negedge clk);
    send_cfg(2, 4);
    t0_data  = 32'h1234_5678;
    t0_valid = 1'b1;
    m_ready  = '1;
    s_valid  = '1;
    i_ready  = 1'b1;
    #1;
    check("midrst_t0_ready", t0_ready, 1);
    check("midrst_m_valid", m_valid, 5'b00100);
    check("midrst_m_last", m_last, 0);
    check("midrst_m_data", m_data, 32'h1234_5678);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst      = 1'b0;
    t0_valid = 1'b0;
    s_valid  = '0;
    #1;
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    // QAM64 len=1: 32 bits -> 6 symbols.
    run_frame(4, 1, 6, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mapper_mode_sched.md
Name: mapper_mode_sched

Overview:
- Per-frame controller that shares one input word stream and one output symbol stream between the constellation mapper lanes (BPSK, QPSK, QAM16, QAM32, QAM64).
- Accepts a frame descriptor (mode, length in 32-bit words), steers that many input words into the selected mapper lane, then forwards and counts that lane's symbols until the frame drains.
- Marks the last symbol of the frame and only then accepts the next descriptor, so modes never interleave on the output.
- Sits between the framer/scrambler and the mapper bank.

Parameters:
- LEN_W, 16, width of descriptor word-count field.
- NUM_LANES, 5, number of mapper lanes; lane index equals mode code.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_data  in  3+LEN_W  {mode[2:0], len[LEN_W-1:0]}
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  descriptor accepted
- t0_data  in  32  input payload word
- t0_valid  in  1  payload valid
- t0_ready  out  1  payload ready
- m_data  out  32  word to mappers, broadcast to all lanes
- m_last  out  1  final word of frame
- m_valid  out  NUM_LANES  one-hot valid to selected lane
- m_ready  in  NUM_LANES  lane readies
- s_data  in  32*NUM_LANES  lane symbol outputs; lane k occupies bits [32k+31:32k]
- s_valid  in  NUM_LANES  lane symbol valids
- s_ready  out  NUM_LANES  lane symbol readies
- i_data  out  32  symbol out
- i_valid  out  1  symbol valid
- i_last  out  1  final symbol of frame
- i_ready  in  1  downstream ready
- busy  out  1  frame in progress
- cfg_err  out  1  one-cycle pulse on rejected descriptor

Behaviour:
- Reset values: all state cleared; all outputs 0, state IDLE.
- Bits per symbol by mode: 0→1, 1→2, 2→4, 3→5, 4→6.
- States: IDLE, FEED, DRAIN.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch mode, words_left=len, and bits_left=32*len (LEN_W+5 bits).
  - If mode>=NUM_LANES or len==0: pulse cfg_err the next cycle and stay in IDLE; the descriptor is consumed.
  - Otherwise go to FEED the next cycle. busy=1 from the FEED cycle onward.
- FEED:
  - m_data=t0_data combinationally.
  - m_valid[mode]=t0_valid; all other m_valid bits are 0.
  - t0_ready=m_ready[mode].
  - m_last=1 when words_left==1.
  - Each handshake decrements words_left.
  - On the handshake with words_left==1, go to DRAIN.
- Symbol path (active in both FEED and DRAIN):
  - i_data=s_data[mode lane]; i_valid=s_valid[mode].
  - s_ready[mode]=i_ready; other s_ready bits are 0.
  - Each output handshake does bits_left -= bps, saturating at 0.
  - i_last=1 when bits_left<=bps; this matches the padded final symbol, ceil(32*len/bps) symbols total.
- DRAIN:
  - t0_ready=0; m_valid=0.
  - On the output handshake with i_last, go to IDLE the next cycle and drop busy.
- Extra symbols: symbols arriving after the final one remain unconsumed (s_ready=0 in IDLE). This is a mapper fault and must not occur.
- Zero-latency paths: all data/valid/ready paths are combinational. The only registered elements are state, mode and counters. Descriptor-to-first-word steering latency is 1 cycle.
- Final symbol during FEED: if it is observed before the last word is sent (impossible for correct mappers), ignore i_last termination until FEED completes.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Partially fed mappers must be reset alongside.
- No backpressure bypass: a stalled lane stalls only this block. Other lanes stay idle.

Test Plan:
- QAM32, len=2 (64 bits): 2 words accepted on lane 3 with m_last on word 2 → exactly 13 symbols out, i_last only on the 13th, then IDLE and busy=0.
- BPSK, len=1: 32 symbols out, i_last on symbol 32; QAM64, len=3: 16 symbols out, i_last on the 16th.
- Descriptor mode=6 and descriptor len=0 → cfg_err pulses once each, no m_valid activity, cfg_ready stays high.
- Random i_ready/m_ready/t0_valid throttling, QAM16 len=5 → 40 symbols with order and data preserved; non-selected lanes see m_valid=0 and s_ready=0 throughout.
- Back-to-back descriptors QPSK len=1 then QAM32 len=1 → second cfg_ready only after QPSK i_last (16 symbols), then 7 QAM32 symbols from lane 3.
- Assert rst mid-FEED → outputs 0 immediately, state IDLE; a new descriptor is then accepted normally.
